// File: rtl/rtc_apb_requester_if.sv
// Command/response and APB bus bundle for the RTC APB requester.
// The master modport is the requester's view; the slave modport is
// the surrounding system (command source plus APB completer).
interface rtc_apb_requester_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    // command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // response side
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    // APB side
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/rtc_apb_requester.sv
// APB requester for the RTC register block: turns one command into one
// APB transfer (IDLE -> SETUP -> ACCESS), with a wait-state timeout, and
// reports completion as a single-cycle response pulse.
module rtc_apb_requester #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    rtc_apb_requester_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait count seen at the start of the last allowed not-ready ACCESS cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  cmd_ready;

    // Ready only in IDLE and never while reset is held.
    assign cmd_ready = (state_q == IDLE) && PRESETn;

    // Next-state and register updates for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d  = SETUP;
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = 8'd0;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    // Completion wins over a timeout landing in the same cycle.
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = IDLE;
                    wait_d      = wait_q + 8'd1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by PRESETn.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_rtc_apb_requester.sv
// Directed bench for rtc_apb_requester: the initial block plays command
// source and APB completer; expected responses go into a queue and are
// matched by a response monitor.
module tb_rtc_apb_requester;

    localparam int TMO = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   rsp_seen = 0;
    int   n_pushed = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    rtc_apb_requester_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    rtc_apb_requester #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .TIMEOUT   (TMO)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge PCLK) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "/cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, "/PSEL"},      32'(bus.PSEL),      32'd0);
        check({tag, "/PENABLE"},   32'(bus.PENABLE),   32'd0);
        check({tag, "/PWRITE"},    32'(bus.PWRITE),    32'd0);
        check({tag, "/PADDR"},     32'(bus.PADDR),     32'd0);
        check({tag, "/PWDATA"},    bus.PWDATA,         32'd0);
        check({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "/rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, "/rsp_rdata"}, bus.rsp_rdata,      32'd0);
    endtask

    // One full command: handshake, SETUP, ACCESS cycles, response, hold.
    task automatic run_xfer(input string name, input logic wr, input logic [11:0] addr,
                            input logic [31:0] wdata, input int waits,
                            input logic [31:0] prdata, input logic slverr,
                            input logic to_exp, input logic exp_err,
                            input logic [31:0] exp_rdata);
        int   n_access;
        rsp_t e;
        @(negedge PCLK);
        check({name, "/ready_idle"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        n_pushed++;
        @(negedge PCLK);
        // SETUP: scramble command inputs and offer a bogus completion
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = ~addr;
        bus.cmd_wdata = ~wdata;
        check({name, "/setup_PSEL"},    32'(bus.PSEL),      32'd1);
        check({name, "/setup_PENABLE"}, 32'(bus.PENABLE),   32'd0);
        check({name, "/setup_ready"},   32'(bus.cmd_ready), 32'd0);
        check({name, "/setup_PADDR"},   32'(bus.PADDR),     32'(addr));
        check({name, "/setup_PWRITE"},  32'(bus.PWRITE),    32'(wr));
        check({name, "/setup_PWDATA"},  bus.PWDATA,         wdata);
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hBAD0_0000;
        n_access = to_exp ? TMO : waits + 1;
        for (int k = 1; k <= n_access; k++) begin
            @(negedge PCLK);
            check({name, "/acc_PSEL"},    32'(bus.PSEL),    32'd1);
            check({name, "/acc_PENABLE"}, 32'(bus.PENABLE), 32'd1);
            check({name, "/acc_PADDR"},   32'(bus.PADDR),   32'(addr));
            check({name, "/acc_PWRITE"},  32'(bus.PWRITE),  32'(wr));
            check({name, "/acc_PWDATA"},  bus.PWDATA,       wdata);
            bus.PRDATA = prdata;
            if (to_exp || k <= waits) begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'b0;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = slverr;
            end
        end
        @(negedge PCLK);
        check({name, "/end_PSEL"},      32'(bus.PSEL),      32'd0);
        check({name, "/end_PENABLE"},   32'(bus.PENABLE),   32'd0);
        check({name, "/end_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({name, "/end_ready"},     32'(bus.cmd_ready), 32'd1);
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hFFFF_FFFF;
        @(negedge PCLK);
        check({name, "/pulse_once"}, 32'(bus.rsp_valid), 32'd0);
        check({name, "/hold_err"},   32'(bus.rsp_err),   32'(exp_err));
        check({name, "/hold_rdata"}, bus.rsp_rdata,      exp_rdata);
        check({name, "/hold_PADDR"}, 32'(bus.PADDR),     32'(addr));
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // reset state
        repeat (3) @(negedge PCLK);
        check_all_zero("reset");
        PRESETn = 1'b1;
        #1;
        check("release/cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // write, no wait states
        run_xfer("wr_basic", 1'b1, 12'h008, 32'h0000_003C, 0, 32'h5555_AAAA, 1'b0, 1'b0,
                 1'b0, 32'h0);
        // read, 3 wait states
        run_xfer("rd_wait3", 1'b0, 12'h000, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0,
                 1'b0, 32'h1234_5678);
        // timeout with PREADY stuck low
        run_xfer("timeout", 1'b0, 12'h010, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1,
                 1'b1, 32'h0);
        // PREADY on the last allowed cycle
        run_xfer("rdy_at_tmo", 1'b0, 12'h014, 32'h0, TMO - 1, 32'h0BAD_F00D, 1'b0, 1'b0,
                 1'b0, 32'h0BAD_F00D);
        // write completing on the last allowed cycle
        run_xfer("wr_at_tmo", 1'b1, 12'h018, 32'h0000_0077, TMO - 1, 32'h1111_1111, 1'b0,
                 1'b0, 1'b0, 32'h0);
        // slave error on a read
        run_xfer("slverr", 1'b0, 12'h004, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0,
                 1'b1, 32'h0);
        // plain read to leave non-zero response data
        run_xfer("rd_plain", 1'b0, 12'h020, 32'h0, 0, 32'hCAFE_0001, 1'b0, 1'b0,
                 1'b0, 32'hCAFE_0001);

        // reset pulse during ACCESS
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 12'h00C;
        bus.cmd_wdata = 32'h0000_00A5;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b0;
        @(negedge PCLK);
        check("rst_mid/in_access", 32'(bus.PENABLE), 32'd1);
        #1;
        PRESETn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        check("rst_mid/ready_after", 32'(bus.cmd_ready), 32'd1);
        repeat (3) @(negedge PCLK);
        check("rst_mid/no_psel", 32'(bus.PSEL), 32'd0);

        // new write after reset completes normally
        run_xfer("wr_after_rst", 1'b1, 12'h004, 32'h0000_0017, 1, 32'h2222_2222, 1'b0, 1'b0,
                 1'b0, 32'h0);

        @(negedge PCLK);
        check("sb/queue_empty", 32'(exp_q.size()), 32'd0);
        check("sb/rsp_count", 32'(rsp_seen), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_apb_requester.md
RTC_APB_REQUESTER -- requirements
Module: rtc_apb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before abort; legal range 1..255.
REQ-004 SHALL have port PCLK, input, 1, the only clock.
REQ-005 SHALL have port PRESETn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted this cycle.
REQ-008 SHALL have port cmd_write, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH: target address.
REQ-010 SHALL have port cmd_wdata, input, DATA_WIDTH: write data.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH: read data; 0 for writes and for errors.
REQ-013 SHALL have port rsp_err, output, 1: PSLVERR or timeout; valid with rsp_valid.
REQ-014 SHALL have ports PSEL, PENABLE and PWRITE, each output, 1: APB control.
REQ-015 SHALL have port PADDR, output, ADDR_WIDTH, and port PWDATA, output, DATA_WIDTH: APB address and write data.
REQ-016 SHALL have port PRDATA, input, DATA_WIDTH, and ports PREADY and PSLVERR, each input, 1: APB completer response; tie PSLVERR to 0 for the RTC.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-018 SHALL drive cmd_ready = 1 only in IDLE; the handshake is cmd_valid & cmd_ready at a PCLK edge.
REQ-019 On handshake, SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA and move IDLE->SETUP.
REQ-020 In SETUP, SHALL drive PSEL=1 and PENABLE=0, and SHALL move to ACCESS unconditionally after one cycle.
REQ-021 In ACCESS, SHALL drive PSEL=1 and PENABLE=1, and SHALL hold PADDR, PWRITE and PWDATA stable until transfer end.
REQ-022 Transfer end: in ACCESS with PREADY=1, SHALL return to IDLE and assert rsp_valid for exactly one cycle in the following cycle.
REQ-023 At transfer end, SHALL set rsp_err = PSLVERR and rsp_rdata = PRDATA if it is a read with PSLVERR=0, else rsp_rdata = 0.
REQ-024 SHALL use an 8-bit wait counter cleared on entry to ACCESS and incremented for each ACCESS cycle with PREADY=0.
REQ-025 When the wait counter reaches TIMEOUT with PREADY still 0, SHALL abort: go to IDLE, drop PSEL and PENABLE, rsp_err=1, rsp_rdata=0.
REQ-026 If PREADY=1 arrives in the same cycle the wait counter reaches TIMEOUT, SHALL treat it as a normal completion, not a timeout.
REQ-027 Outside SETUP/ACCESS, SHALL hold PSEL=0 and PENABLE=0; PADDR, PWRITE and PWDATA keep their last values.
REQ-028 Minimum throughput: one transfer per 3 PCLK cycles (IDLE, SETUP, ACCESS); no back-to-back ACCESS->SETUP.
REQ-029 SHALL ignore PREADY, PRDATA and PSLVERR outside ACCESS.
REQ-030 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.

Reset
REQ-031 With PRESETn=0, SHALL immediately force state IDLE and set PSEL, PENABLE, PWRITE, rsp_valid and rsp_err to 0, and PADDR, PWDATA and rsp_rdata to 0, with the wait counter at 0.
REQ-032 cmd_ready SHALL be 0 while PRESETn=0 and SHALL be 1 in the first cycle after release.
REQ-033 Reset asserted mid-transfer SHALL abort it silently, with no rsp_valid after release.

Verification
REQ-034 Write with PREADY tied 1: cmd addr=0x008 wdata=0x0000_003C -> PSEL for 2 cycles, PENABLE only in the 2nd, PWRITE=1; rsp_valid=1 with rsp_err=0 and rsp_rdata=0.
REQ-035 Read with 3 wait states: addr=0x000, PRDATA=0x1234_5678 with PREADY=1 on the 4th ACCESS cycle -> rsp_rdata=0x1234_5678, rsp_err=0; PADDR is stable throughout.
REQ-036 Timeout at TIMEOUT=4 with PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles; rsp_err=1 and rsp_rdata=0.
REQ-037 PREADY=1 exactly on the TIMEOUT-th cycle -> normal completion with rsp_err=0.
REQ-038 PSLVERR=1 on a read completion with PRDATA=0xDEAD_BEEF -> rsp_err=1 and rsp_rdata=0.
REQ-039 PRESETn pulsed low during ACCESS -> all outputs 0 at once and no rsp_valid; after release, a new write completes normally.
